fe_stage: RTL and testbench
===========================

# fe_stage

Instruction-fetch stage of the segmented RV32I core, sitting directly upstream of the decode stage. Holds the program counter and drives the instruction-memory address. Registers the fetched word into the IF/DE pipeline register that feeds decode's `inst_de`. Honours load-use stalls and clears from the hazard detection unit, and branch/jump redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) inserted on reset and flush.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hazard unit hold request: freeze PC and IF/DE.
- `clr`  in  1  hazard unit clear: load bubble into IF/DE.
- `br_taken_ex`  in  1  execute-stage redirect (taken branch or jump).
- `br_target_ex`  in  32  redirect target address.
- `imem_addr`  out  32  instruction-memory byte address; combinational from PC.
- `imem_rdata`  in  32  instruction word at `imem_addr`; combinational read.
- `pc_fe`  out  32  current fetch PC.
- `inst_de`  out  32  IF/DE instruction to decode.
- `pc_de`  out  32  PC of `inst_de`.
- `pc4_de`  out  32  `pc_de + 4`.
- `valid_de`  out  1  `inst_de` is a real fetched instruction, not a bubble.
- `fetch_count`  out  32  number of instructions accepted into IF/DE since reset.

## Operation
- State: PC register, IF/DE register (`inst_de`, `pc_de`, `pc4_de`, `valid_de`), `fetch_count`.
- `imem_addr = pc_fe`. `pc_next_seq = pc_fe + 4`, mod 2^32. Wrap from 32'hFFFF_FFFC to 0 needs no special handling.
- Redirect target is aligned by forcing `br_target_ex[1:0]` to 2'b00. The lower bits are ignored, with no fault.
- Per-edge update, highest priority first:
  1. `!rst_n`: PC ← `RESET_PC`; `inst_de` ← `NOP_INST`; `pc_de` ← 0; `pc4_de` ← 0; `valid_de` ← 0; `fetch_count` ← 0.
  2. `br_taken_ex`: PC ← aligned target; IF/DE ← bubble (`NOP_INST`, `valid_de`=0; `pc_de`/`pc4_de` hold). This overrides `stall` and `clr`.
  3. `stall`: PC holds; IF/DE holds all fields. A coincident `clr` is ignored.
  4. `clr`: PC ← `pc_next_seq`; IF/DE ← bubble. The fetched word is discarded.
  5. Otherwise: PC ← `pc_next_seq`; `inst_de` ← `imem_rdata`; `pc_de` ← `pc_fe`; `pc4_de` ← `pc_next_seq`; `valid_de` ← 1.
- `fetch_count` increments by 1 only in case 5. It wraps at 2^32.
- No FSM beyond the priority mux. The stage is always fetching.

## Timing
- Reset values: `pc_fe`/`imem_addr` = `RESET_PC`; `inst_de` = `NOP_INST`; `pc_de` = `pc4_de` = 0; `valid_de` = 0; `fetch_count` = 0. Reset takes effect at the first rising edge with `rst_n`=0 and applies even mid-stall or mid-redirect.
- Fetch latency: the word at address A appears on `inst_de` one edge after `pc_fe` = A, if that edge is case 5.
- First edge after reset release: `inst_de` = mem[RESET_PC], `pc_fe` = RESET_PC+4.
- Redirect penalty: on the redirect edge, IF/DE becomes a bubble and `pc_fe` = target. The next edge loads mem[target]. Decode's in-flight instruction is squashed by the downstream DE/EX clear, not here.
- Stall of N cycles holds `pc_fe` and IF/DE for exactly N edges. There is no loss and no duplication.
- `stall` and `clr` are sampled only at edges. They are assumed glitch-free before setup.

## Test plan
- Reset/sequential: hold `rst_n`=0 for 2 cycles, release with mem[0x0]=0x00500093 and mem[0x4]=0x00A00113 → after edge 1, `inst_de`=0x00500093, `pc_de`=0, `pc4_de`=4, `pc_fe`=8 after edge 2, `fetch_count`=2.
- Stall: assert `stall` 3 cycles while `pc_fe`=0x10 → `pc_fe` stays 0x10 and `inst_de` is unchanged for 3 edges. Release → mem[0x10] is loaded and `fetch_count` advances by 1, not 4.
- Clear: `clr`=1 for one edge at `pc_fe`=0x20 → `inst_de`=0x00000013, `valid_de`=0, `pc_fe`=0x24, `fetch_count` unchanged.
- Redirect vs stall: `br_taken_ex`=1, `br_target_ex`=0x0000_0103, and `stall`=1 on the same edge → `pc_fe`=0x100, `inst_de`=NOP, `valid_de`=0. The next edge loads mem[0x100].
- Wrap and reset mid-run: redirect to 0xFFFF_FFFC, then one normal edge → `pc_fe`=0, `pc_de`=0xFFFF_FFFC, `pc4_de`=0. Then assert `rst_n`=0 during `stall` → all outputs return to reset values at that edge.

Source files
------------

// File: rtl/fe_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/DE pipeline register under redirect/stall/clear control.
module fe_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        clr,
    input  logic        br_taken_ex,
    input  logic [31:0] br_target_ex,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_fe,
    output logic [31:0] inst_de,
    output logic [31:0] pc_de,
    output logic [31:0] pc4_de,
    output logic        valid_de,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_p0;
    logic [31:0] pc_next_seq;
    logic [31:0] br_target_aligned;

    assign pc_next_seq       = pc_p0 + 32'd4;
    assign br_target_aligned = {br_target_ex[31:2], 2'b00};
    assign imem_addr         = pc_p0;
    assign pc_fe             = pc_p0;

    // PC -> IF/DE stage boundary; redirect beats stall, stall beats clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0       <= RESET_PC;
            inst_de     <= NOP_INST;
            pc_de       <= 32'd0;
            pc4_de      <= 32'd0;
            valid_de    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (br_taken_ex) begin
            pc_p0    <= br_target_aligned;
            inst_de  <= NOP_INST;
            valid_de <= 1'b0;
        end else if (stall) begin
            pc_p0 <= pc_p0;
        end else if (clr) begin
            pc_p0    <= pc_next_seq;
            inst_de  <= NOP_INST;
            valid_de <= 1'b0;
        end else begin
            pc_p0       <= pc_next_seq;
            inst_de     <= imem_rdata;
            pc_de       <= pc_p0;
            pc4_de      <= pc_next_seq;
            valid_de    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fe_stage.sv
// Directed plus randomized bench for fe_stage with a queue-based scoreboard.
module tb_fe_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        clr;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_fe;
    logic [31:0] inst_de;
    logic [31:0] pc_de;
    logic [31:0] pc4_de;
    logic        valid_de;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcde;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_inst, m_pcde, m_pc4, m_cnt;
    logic        m_valid;

    fe_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .clr          (clr),
        .br_taken_ex  (br_taken_ex),
        .br_target_ex (br_target_ex),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc_fe        (pc_fe),
        .inst_de      (inst_de),
        .pc_de        (pc_de),
        .pc4_de       (pc4_de),
        .valid_de     (valid_de),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_f = 32'h0050_0093;
            32'h0000_0004: mem_f = 32'h00A0_0113;
            default:       mem_f = a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always_comb imem_rdata = mem_f(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference model with the inputs now applied, then compare after the edge.
    task automatic step();
        exp_t e;
        if (!rst_n) begin
            m_pc = 32'h0; m_inst = NOP; m_pcde = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (br_taken_ex) begin
            m_pc = br_target_ex & 32'hFFFF_FFFC; m_inst = NOP; m_valid = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (clr) begin
            m_pc = m_pc + 32'd4; m_inst = NOP; m_valid = 1'b0;
        end else begin
            m_inst = mem_f(m_pc); m_pcde = m_pc; m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        e.pc = m_pc; e.inst = m_inst; e.pcde = m_pcde; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("pc_fe", pc_fe, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("inst_de", inst_de, e.inst);
            chk("pc_de", pc_de, e.pcde);
            chk("pc4_de", pc4_de, e.pc4);
            chk("valid_de", {31'd0, valid_de}, {31'd0, e.valid});
            chk("fetch_count", fetch_count, e.cnt);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic c, input logic b, input logic [31:0] t);
        rst_n = r; stall = s; clr = c; br_taken_ex = b; br_target_ex = t;
    endtask

    initial begin
        m_pc = '0; m_inst = '0; m_pcde = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();

        // reset release and sequential fetch
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("seq_inst0", inst_de, 32'h0050_0093);
        chk("seq_pcde0", pc_de, 32'h0);
        chk("seq_pc4de0", pc4_de, 32'h4);
        step();
        chk("seq_pc8", pc_fe, 32'h8);
        chk("seq_cnt2", fetch_count, 32'd2);
        chk("seq_inst1", inst_de, 32'h00A0_0113);
        step();
        step();
        chk("pre_stall_pc", pc_fe, 32'h10);

        // three-cycle stall at 0x10
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_fe, 32'h10);
            chk("stall_inst", inst_de, 32'h0000_000C ^ 32'hC0DE_0000);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("unstall_inst", inst_de, 32'h0000_0010 ^ 32'hC0DE_0000);
        chk("unstall_cnt", fetch_count, 32'd5);
        step(); step(); step();

        // clear at 0x20
        chk("pre_clr_pc", pc_fe, 32'h20);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("clr_inst", inst_de, NOP);
        chk("clr_valid", {31'd0, valid_de}, 32'd0);
        chk("clr_pc", pc_fe, 32'h24);
        chk("clr_cnt", fetch_count, 32'd8);

        // redirect with coincident stall, unaligned target
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        step();
        chk("br_pc", pc_fe, 32'h100);
        chk("br_inst", inst_de, NOP);
        chk("br_valid", {31'd0, valid_de}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("br_fetch", inst_de, 32'h0000_0100 ^ 32'hC0DE_0000);
        chk("br_pcde", pc_de, 32'h100);

        // wrap at top of address space
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step();
        chk("wrap_tgt", pc_fe, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_pc", pc_fe, 32'h0);
        chk("wrap_pcde", pc_de, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4_de, 32'h0);

        // reset during stall and redirect
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
        step();
        chk("rst_pc", pc_fe, 32'h0);
        chk("rst_inst", inst_de, NOP);
        chk("rst_cnt", fetch_count, 32'd0);

        for (int i = 0; i < 60; i++) begin
            drive(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
